// File: rtl/midi_tx_if.sv
// midi_tx_if: byte handshake and line signals between the MIDI message source and midi_tx.
// Ports: midiData_i/dataValid_i (source -> tx), dataReady_o (tx -> source),
//        txData_o (serial MIDI OUT line), busy_o (frame on line or bytes queued).
interface midi_tx_if;
  logic [7:0] midiData_i;
  logic       dataValid_i;
  logic       dataReady_o;
  logic       txData_o;
  logic       busy_o;

  // Message generator side: offers bytes, observes ready/line/busy.
  modport master (
    output midiData_i,
    output dataValid_i,
    input  dataReady_o,
    input  txData_o,
    input  busy_o
  );

  // Transmitter side.
  modport slave (
    input  midiData_i,
    input  dataValid_i,
    output dataReady_o,
    output txData_o,
    output busy_o
  );
endinterface

// File: rtl/midi_tx.sv
// midi_tx: MIDI serial transmitter, 8N1 frames at BAUD, bytes queued in a FIFO_DEPTH-entry FIFO.
// Latency: byte pushed into an empty FIFO while idle starts its start bit on the next edge.
// Backpressure: dataReady_o low while the FIFO is full; a held byte is taken once space frees.
// Ports: clk_i, rst_i (async, active-high); bus (slave modport): midiData_i, dataValid_i,
//        dataReady_o, txData_o (registered, idles high), busy_o (registered).
module midi_tx #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 31_250,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  midi_tx_if.slave bus
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BAUD;
  localparam int CW             = $clog2(CYCLES_PER_BIT) + 1;
  localparam int AW             = $clog2(FIFO_DEPTH);
  localparam int NW             = AW + 1;

  localparam logic [CW-1:0] LAST_CYC = CW'(CYCLES_PER_BIT - 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [NW-1:0] r_count;
  logic [NW-1:0] w_count_nxt;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_nempty;
  logic [7:0]    w_head;

  // Serialiser state
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_tx;
  logic          w_tx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic [CW-1:0] r_cyc;
  logic [CW-1:0] w_cyc_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic          r_busy;
  logic          w_busy_nxt;
  logic          w_bit_end;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign w_ready         = (r_count != FULL_CNT);
  assign w_push          = bus.dataValid_i && w_ready;
  assign w_fifo_nempty   = (r_count != '0);
  assign w_head          = r_mem[r_rptr];
  assign bus.dataReady_o = w_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Payload storage needs no reset: an entry is only read after being written.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.midiData_i;
    end
  end

  // Pointers are exactly AW bits wide, so the natural overflow gives the
  // modulo-FIFO_DEPTH wrap for power-of-two depths.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM: state register
  // ---------------------------------------------------------------------------
  assign w_bit_end = (r_cyc == LAST_CYC);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_shift <= '0;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_shift <= w_shift_nxt;
      r_cyc   <= w_cyc_nxt;
      r_bit   <= w_bit_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM: next state and next line level
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_shift_nxt = r_shift;
    w_cyc_nxt   = r_cyc;
    w_bit_nxt   = r_bit;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_fifo_nempty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
          w_cyc_nxt   = '0;
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_tx_nxt    = r_shift[0];
          w_bit_nxt   = '0;
          w_cyc_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_cyc_nxt = r_cyc + 1'b1;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_cyc_nxt = '0;
          if (r_bit == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            // Shift right; the bit landing in position 0 is the next one on the line.
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
            w_bit_nxt   = r_bit + 1'b1;
          end
        end else begin
          w_cyc_nxt = r_cyc + 1'b1;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_cyc_nxt = '0;
          if (w_fifo_nempty) begin
            // Chain straight into the next start bit so bursts have no idle gap.
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cyc_nxt = r_cyc + 1'b1;
        end
      end

      default: begin
        w_tx_nxt    = 1'b1;
        w_cyc_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // busy is registered from next-state values so it is aligned with the line:
  // it rises with the push and falls on the edge that ends the last stop bit.
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
  end

  assign bus.txData_o = r_tx;
  assign bus.busy_o   = r_busy;

endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: scoreboard bench for midi_tx at CLK_HZ=1 MHz, BAUD=31250 (32 cycles per bit).
// Accepted bytes go into a queue; a line monitor decodes frames and pops/compares them.
module tb_midi_tx;

  localparam int CPB   = 32;
  localparam int FRAME = 10 * CPB;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  midi_tx_if bus();

  midi_tx #(
    .CLK_HZ    (1_000_000),
    .BAUD      (31_250),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [7:0] sb_q[$];
  int         starts_q[$];
  int         frames = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line monitor: samples on the falling clock edge. Each bit period is sampled
  // at its first, middle and last cycle so a wrong period length shows up.
  // ---------------------------------------------------------------------------
  bit         mon_act = 1'b0;
  int         mon_start;
  logic [9:0] mid_bits;
  logic [9:0] first_bits;
  bit         unstable;

  always @(negedge clk_i or posedge rst_i) begin
    int off;
    int k;
    int r;
    logic [7:0] exp_b;
    if (rst_i) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (bus.txData_o === 1'b0) begin
        mon_act    = 1'b1;
        mon_start  = cyc;
        unstable   = 1'b0;
        first_bits = '0;
        mid_bits   = '0;
        starts_q.push_back(cyc);
      end
    end else begin
      off = cyc - mon_start;
      k   = off / CPB;
      r   = off % CPB;
      if (r == 0) first_bits[k] = bus.txData_o;
      if (r == CPB / 2) mid_bits[k] = bus.txData_o;
      if (r == CPB - 1 && (bus.txData_o !== first_bits[k] || bus.txData_o !== mid_bits[k]))
        unstable = 1'b1;
      if (off == FRAME - 1) begin
        mon_act = 1'b0;
        frames++;
        chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_b = sb_q.pop_front();
          chk("rx_byte", 32'(mid_bits[8:1]), 32'(exp_b));
        end
        chk("framing", 32'({mid_bits[9], mid_bits[0]}), 32'b10);
        chk("bit_period", 32'(unstable), 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input int budget, output int acc_cyc);
    bit rdy;
    bit accepted;
    int n;
    bus.midiData_i  = b;
    bus.dataValid_i = 1'b1;
    accepted = 1'b0;
    n        = 0;
    acc_cyc  = -1;
    while (!accepted && n < budget) begin
      rdy = bus.dataReady_o;
      @(posedge clk_i);
      #1;
      if (rdy) begin
        accepted = 1'b1;
        acc_cyc  = cyc;
        sb_q.push_back(b);
      end
      n++;
    end
    if (!accepted) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_busy_low(input int budget, output int at);
    int n;
    at = -1;
    n  = 0;
    while (n < budget) begin
      @(posedge clk_i);
      #1;
      if (!bus.busy_o) begin
        at = cyc;
        break;
      end
      n++;
    end
    if (at < 0) chk("busy_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_gaps(input int nexp);
    chk("start_count", 32'(starts_q.size()), 32'(nexp));
    for (int i = 1; i < starts_q.size(); i++)
      chk("b2b_gap", 32'(starts_q[i] - starts_q[i-1]), 32'(FRAME));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    int m;
    int lows;
    int fr0;
    int acc[6];

    bus.midiData_i  = 8'h00;
    bus.dataValid_i = 1'b0;
    rst_i           = 1'b1;
    #1;
    chk("rst_tx", 32'(bus.txData_o), 32'd1);
    chk("rst_rdy", 32'(bus.dataReady_o), 32'd1);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Asynchronous reset during a start bit.
    send_byte(8'hA5, 10, n);
    bus.dataValid_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("a5_fall", 32'(bus.txData_o), 32'd0);
    repeat (5) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("arst_tx", 32'(bus.txData_o), 32'd1);
    chk("arst_rdy", 32'(bus.dataReady_o), 32'd1);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Single byte 0x90: timing of fall and busy.
    starts_q.delete();
    send_byte(8'h90, 10, n);
    bus.dataValid_i = 1'b0;
    chk("busy_rise", 32'(bus.busy_o), 32'd1);
    chk("pre_fall", 32'(bus.txData_o), 32'd1);
    @(posedge clk_i);
    #1;
    chk("fall_n1", 32'(bus.txData_o), 32'd0);
    wait_busy_low(400, t);
    chk("busy_fall", 32'(t - n), 32'd321);
    check_gaps(1);
    if (starts_q.size() == 1) chk("start_at_n1", 32'(starts_q[0] - n), 32'd1);
    chk("sb_drain1", 32'(sb_q.size()), 32'd0);

    // Three-byte burst.
    starts_q.delete();
    send_byte(8'h90, 10, n);
    send_byte(8'h3C, 10, t);
    send_byte(8'h7F, 10, t);
    bus.dataValid_i = 1'b0;
    wait_busy_low(1200, t);
    chk("burst_len", 32'(t - n), 32'd961);
    check_gaps(3);
    chk("sb_drain3", 32'(sb_q.size()), 32'd0);

    // Overflow: six bytes with valid held high.
    starts_q.delete();
    for (int i = 0; i < 6; i++) begin
      send_byte(8'((i + 1) * 8'h11), 400, acc[i]);
      if (i == 4) chk("full_rdy", 32'(bus.dataReady_o), 32'd0);
    end
    bus.dataValid_i = 1'b0;
    chk("acc5_edge", 32'(acc[4] - acc[0]), 32'd4);
    chk("acc6_edge", 32'(acc[5] - acc[0]), 32'd322);
    wait_busy_low(2500, t);
    chk("ovf_len", 32'(t - acc[0]), 32'(1 + 6 * FRAME));
    check_gaps(6);
    chk("sb_drain6", 32'(sb_q.size()), 32'd0);

    // Reset during data bit 4 of 0x55 with two bytes queued.
    starts_q.delete();
    send_byte(8'h55, 10, n);
    send_byte(8'hAA, 10, t);
    send_byte(8'hCC, 10, t);
    bus.dataValid_i = 1'b0;
    m = 0;
    while (cyc < n + 1 + 5 * CPB + CPB / 2 && m < 400) begin
      @(posedge clk_i);
      #1;
      m++;
    end
    #2 rst_i = 1'b1;
    #1;
    chk("mrst_tx", 32'(bus.txData_o), 32'd1);
    chk("mrst_rdy", 32'(bus.dataReady_o), 32'd1);
    chk("mrst_busy", 32'(bus.busy_o), 32'd0);
    sb_q.delete();
    fr0 = frames;
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    lows = 0;
    repeat (700) begin
      @(posedge clk_i);
      #1;
      if (!bus.txData_o || bus.busy_o) lows++;
    end
    chk("post_rst_quiet", 32'(lows), 32'd0);
    chk("post_rst_frames", 32'(frames - fr0), 32'd0);
    send_byte(8'hF8, 10, n);
    bus.dataValid_i = 1'b0;
    wait_busy_low(400, t);
    chk("f8_len", 32'(t - n), 32'd321);
    chk("f8_frames", 32'(frames - fr0), 32'd1);
    chk("sb_drain_f8", 32'(sb_q.size()), 32'd0);

    // Push on the same edge that ends a stop bit and pops the queued byte.
    starts_q.delete();
    send_byte(8'h12, 10, n);
    send_byte(8'h34, 10, t);
    bus.dataValid_i = 1'b0;
    m = 0;
    while (cyc < n + FRAME && m < 400) begin
      @(posedge clk_i);
      #1;
      m++;
    end
    chk("pre_cnt", 32'(dut.r_count), 32'd1);
    send_byte(8'h56, 10, m);
    bus.dataValid_i = 1'b0;
    chk("sim_edge", 32'(m - n), 32'd321);
    chk("sim_cnt", 32'(dut.r_count), 32'd1);
    wait_busy_low(1200, t);
    chk("sim_len", 32'(t - n), 32'd961);
    check_gaps(3);
    chk("sb_drain_sim", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
